// File: rtl/req_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : req_scheduler_if
// Description : Request/grant bundle for the 16-way round-robin scheduler.
//               master - requester side: drives req_a/req_b/done, observes
//                        the grant outputs.
//               slave  - scheduler side: observes requests, drives grants.
// Signals     : req_a[7:0]         requesters 15..8 (req_a[7] = 15)
//               req_b[7:0]         requesters 7..0  (req_b[0] = 0)
//               done               release pulse from the current owner
//               grant_valid        a grant is held
//               grant_idx[7:0]     owner index 0..15, 8'hF0 when idle
//               grant_onehot[15:0] one-hot owner, zero when idle
//               preempt            one-cycle pulse after a timeout release
// Revision    : 1.0 - initial release
// ============================================================================
interface req_scheduler_if;
    logic [7:0]  req_a;
    logic [7:0]  req_b;
    logic        done;
    logic        grant_valid;
    logic [7:0]  grant_idx;
    logic [15:0] grant_onehot;
    logic        preempt;

    modport master (
        output req_a,
        output req_b,
        output done,
        input  grant_valid,
        input  grant_idx,
        input  grant_onehot,
        input  preempt
    );

    modport slave (
        input  req_a,
        input  req_b,
        input  done,
        output grant_valid,
        output grant_idx,
        output grant_onehot,
        output preempt
    );
endinterface
`default_nettype wire

// File: rtl/req_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : req_scheduler
// Description : 16-requester round-robin scheduler with a bounded hold time.
//               A winner is picked in IDLE and held in BUSY until the owner
//               pulses done, drops its request, or has held the grant for
//               HOLD_MAX cycles. A timeout release that the owner did not
//               agree to is flagged with a one-cycle preempt pulse. Every
//               release is followed by at least one idle cycle.
// Parameters  : HOLD_MAX  maximum consecutive grant cycles, 1..15
// Ports       : clk       rising-edge clock
//               rst       synchronous active-high reset
//               bus       req_scheduler_if.slave (requests in, grant out)
// Revision    : 1.0 - initial release
// ============================================================================
module req_scheduler #(
    parameter int HOLD_MAX = 15
) (
    input  wire logic           clk,
    input  wire logic           rst,
    req_scheduler_if.slave      bus
);

    localparam logic [3:0]  c_hold_max = 4'(HOLD_MAX);
    localparam logic [7:0]  c_no_grant = 8'hF0;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_last_idx;
    logic [3:0]  w_last_idx_nxt;
    logic [3:0]  r_owner;
    logic [3:0]  w_owner_nxt;
    logic [3:0]  r_hold_cnt;
    logic [3:0]  w_hold_cnt_nxt;

    logic        r_grant_valid;
    logic        w_grant_valid_nxt;
    logic [7:0]  r_grant_idx;
    logic [7:0]  w_grant_idx_nxt;
    logic [15:0] r_grant_onehot;
    logic [15:0] w_grant_onehot_nxt;
    logic        r_preempt;
    logic        w_preempt_nxt;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [15:0] w_req;
    logic [3:0]  w_win_idx;
    logic [3:0]  w_cand;
    logic        w_owner_req;
    logic        w_timeout;
    logic        w_release;

    assign w_req = {bus.req_a, bus.req_b};

    // Round-robin pick. Candidates are visited from the lowest priority
    // (last_idx itself) up to the highest (last_idx-1); a later hit
    // overrides an earlier one, so the surviving winner is the first
    // asserted line in descending scan order starting at last_idx-1.
    // The 4-bit subtraction supplies the 0 -> 15 wrap for free.
    always_comb begin
        w_win_idx = r_last_idx;
        w_cand    = '0;
        for (int i = 16; i >= 1; i--) begin
            w_cand = r_last_idx - 4'(i);
            if (w_req[w_cand]) begin
                w_win_idx = w_cand;
            end
        end
    end

    assign w_owner_req = w_req[r_owner];
    assign w_timeout   = (r_hold_cnt == c_hold_max);
    assign w_release   = bus.done || !w_owner_req || w_timeout;

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt        = r_state;
        w_last_idx_nxt     = r_last_idx;
        w_owner_nxt        = r_owner;
        w_hold_cnt_nxt     = r_hold_cnt;
        w_grant_valid_nxt  = r_grant_valid;
        w_grant_idx_nxt    = r_grant_idx;
        w_grant_onehot_nxt = r_grant_onehot;
        w_preempt_nxt      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // done is meaningless without an owner and is not looked at.
                if (|w_req) begin
                    w_state_nxt        = ST_BUSY;
                    w_owner_nxt        = w_win_idx;
                    w_hold_cnt_nxt     = 4'd1;
                    w_grant_valid_nxt  = 1'b1;
                    w_grant_idx_nxt    = {4'h0, w_win_idx};
                    w_grant_onehot_nxt = 16'h0001 << w_win_idx;
                end
            end

            ST_BUSY: begin
                if (w_release) begin
                    w_state_nxt        = ST_IDLE;
                    w_last_idx_nxt     = r_owner;
                    w_hold_cnt_nxt     = 4'd0;
                    w_grant_valid_nxt  = 1'b0;
                    w_grant_idx_nxt    = c_no_grant;
                    w_grant_onehot_nxt = 16'h0000;
                    // Only a release forced purely by the hold limit counts
                    // as a preemption; a cooperative release on the same
                    // edge takes precedence.
                    w_preempt_nxt      = w_timeout && !bus.done && w_owner_req;
                end else begin
                    // Cannot pass HOLD_MAX: the timeout release fires first.
                    w_hold_cnt_nxt     = r_hold_cnt + 4'd1;
                end
            end

            default: begin
                w_state_nxt        = ST_IDLE;
                w_hold_cnt_nxt     = 4'd0;
                w_grant_valid_nxt  = 1'b0;
                w_grant_idx_nxt    = c_no_grant;
                w_grant_onehot_nxt = 16'h0000;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_last_idx     <= 4'd0;
            r_owner        <= 4'd0;
            r_hold_cnt     <= 4'd0;
            r_grant_valid  <= 1'b0;
            r_grant_idx    <= c_no_grant;
            r_grant_onehot <= 16'h0000;
            r_preempt      <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_last_idx     <= w_last_idx_nxt;
            r_owner        <= w_owner_nxt;
            r_hold_cnt     <= w_hold_cnt_nxt;
            r_grant_valid  <= w_grant_valid_nxt;
            r_grant_idx    <= w_grant_idx_nxt;
            r_grant_onehot <= w_grant_onehot_nxt;
            r_preempt      <= w_preempt_nxt;
        end
    end

    assign bus.grant_valid  = r_grant_valid;
    assign bus.grant_idx    = r_grant_idx;
    assign bus.grant_onehot = r_grant_onehot;
    assign bus.preempt      = r_preempt;

endmodule
`default_nettype wire
